// File: rtl/zoom_pio_pkg.sv
// Shared definitions for the zoom PIO command path: sequencer states and
// the PIO register map/reset value.
package zoom_pio_pkg;

  localparam int         PIO_DATA_W    = 10;
  localparam logic [9:0] PIO_RESET_VAL = 10'h3FF;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    VERIFY = 2'd2,
    HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/zoom_cmd_fifo.sv
// Small synchronous command FIFO. Head data is visible combinationally;
// a push while full is accepted only when a pop frees a slot in the same cycle.
module zoom_cmd_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == FULL_LVL);
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers rely on DEPTH being a power of two to wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/zoom_pio_cmd_sequencer.sv
// Round-robin arbitration of two command sources into a FIFO, then one
// write + readback verify per command to the PIO, followed by a hold gap.
module zoom_pio_cmd_sequencer
  import zoom_pio_pkg::*;
#(
  parameter int DATA_W      = PIO_DATA_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          req0,
  input  logic [DATA_W-1:0]             data0,
  output logic                          ack0,
  input  logic                          req1,
  input  logic [DATA_W-1:0]             data1,
  output logic                          ack1,
  output logic [1:0]                    pio_address,
  output logic                          pio_chipselect,
  output logic                          pio_write_n,
  output logic [31:0]                   pio_writedata,
  input  logic [31:0]                   pio_readdata,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DATA_W-1:0]             last_cmd,
  output logic                          err_mismatch,
  input  logic                          err_clear
);

  state_t             state;
  logic [DATA_W-1:0]  cmd;
  logic [CNT_W-1:0]   hold_cnt;
  logic               rr;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               can_push;
  logic               elig0;
  logic               elig1;
  logic               grant0;
  logic               grant1;
  logic [DATA_W-1:0]  push_data;
  logic [DATA_W-1:0]  fifo_head;
  logic               mismatch;

  always_comb begin
    fifo_pop  = (state == IDLE) && !fifo_empty;
    can_push  = !fifo_full || fifo_pop;
    // A requester being acked this cycle still shows req; mask it out.
    elig0     = req0 && !ack0 && can_push;
    elig1     = req1 && !ack1 && can_push;
    grant0    = elig0 && (!elig1 || !rr);
    grant1    = elig1 && (!elig0 || rr);
    push_data = grant1 ? data1 : data0;
    mismatch  = (pio_readdata != {{(32-DATA_W){1'b0}}, cmd});
  end

  zoom_cmd_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (grant0 || grant1),
    .push_data (push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign pio_address = PIO_DATA_ADDR;
  assign busy        = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rr   <= 1'b0;
    end else begin
      ack0 <= grant0;
      ack1 <= grant1;
      if (grant0)      rr <= 1'b1;
      else if (grant1) rr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cmd            <= '0;
      hold_cnt       <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
      last_cmd       <= DATA_W'(PIO_RESET_VAL);
      err_mismatch   <= 1'b0;
    end else begin
      if ((state == VERIFY) && mismatch) err_mismatch <= 1'b1;
      else if (err_clear)                err_mismatch <= 1'b0;

      case (state)
        IDLE: begin
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          if (!fifo_empty) begin
            cmd            <= fifo_head;
            pio_writedata  <= {{(32-DATA_W){1'b0}}, fifo_head};
            pio_chipselect <= 1'b1;
            pio_write_n    <= 1'b0;
            state          <= WRITE;
          end
        end
        WRITE: begin
          pio_chipselect <= 1'b1;
          pio_write_n    <= 1'b1;
          state          <= VERIFY;
        end
        VERIFY: begin
          pio_chipselect <= 1'b0;
          pio_write_n    <= 1'b1;
          last_cmd       <= cmd;
          hold_cnt       <= CNT_W'(HOLD_CYCLES);
          state          <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0) state <= IDLE;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zoom_pio_cmd_sequencer.sv
// Directed bench: main instance with default hold, second instance with
// zero hold for back-to-back arbitration; PIO slave modelled as a register.
module tb_zoom_pio_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0 = 0, req1 = 0, err_clear = 0, corrupt = 0;
  logic [9:0]  data0 = '0, data1 = '0;
  logic        ack0, ack1, cs, wn, busy, err;
  logic [1:0]  addr;
  logic [31:0] wd, rd;
  logic [2:0]  level;
  logic [9:0]  last_cmd;
  logic [9:0]  pio_reg;
  logic [9:0]  wlog [$];

  logic        h_req0 = 0, h_req1 = 0;
  logic [9:0]  h_data0 = 10'h001, h_data1 = 10'h002;
  logic        h_ack0, h_ack1, h_cs, h_wn, h_busy, h_err;
  logic [1:0]  h_addr;
  logic [31:0] h_wd, h_rd;
  logic [2:0]  h_level;
  logic [9:0]  h_last;
  logic [9:0]  h_reg;

  zoom_pio_cmd_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .pio_address(addr), .pio_chipselect(cs), .pio_write_n(wn),
    .pio_writedata(wd), .pio_readdata(rd),
    .busy(busy), .fifo_level(level), .last_cmd(last_cmd),
    .err_mismatch(err), .err_clear(err_clear)
  );

  zoom_pio_cmd_sequencer #(.HOLD_CYCLES(0)) dut_h0 (
    .clk(clk), .reset_n(reset_n),
    .req0(h_req0), .data0(h_data0), .ack0(h_ack0),
    .req1(h_req1), .data1(h_data1), .ack1(h_ack1),
    .pio_address(h_addr), .pio_chipselect(h_cs), .pio_write_n(h_wn),
    .pio_writedata(h_wd), .pio_readdata(h_rd),
    .busy(h_busy), .fifo_level(h_level), .last_cmd(h_last),
    .err_mismatch(h_err), .err_clear(1'b0)
  );

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_reg <= 10'h3FF;
      h_reg   <= 10'h3FF;
    end else begin
      if (cs && !wn) begin
        pio_reg <= wd[9:0];
        wlog.push_back(wd[9:0]);
      end
      if (h_cs && !h_wn) h_reg <= h_wd[9:0];
    end
  end
  assign rd   = {22'b0, pio_reg ^ (corrupt ? 10'h001 : 10'h000)};
  assign h_rd = {22'b0, h_reg};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit sel, input logic [9:0] d);
    if (sel) begin data1 = d; req1 = 1'b1; end
    else     begin data0 = d; req0 = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel ? ack1 : ack0) break;
    end
    chk(sel ? "ack1_seen" : "ack0_seen", sel ? ack1 : ack0, 1);
    if (sel) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic wait_write(output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      n++;
      if (cs && !wn) break;
    end
  endtask

  // Zero-hold instance, both requesters held: expected per negedge 1..14.
  int e_ack0 [14] = '{1,0,1,0,1,0,0,0,0,1,0,0,0,0};
  int e_ack1 [14] = '{0,1,0,1,0,1,0,0,0,0,0,0,0,1};
  int e_lvl  [14] = '{1,1,2,3,4,4,4,4,4,4,4,4,4,4};
  int e_wr   [14] = '{0,1,0,0,0,2,0,0,0,1,0,0,0,2};
  int e_order[6]  = '{'h100,'h201,'h202,'h203,'h204,'h205};

  initial begin
    int n;

    // Reset and quiet idle
    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 0);
    chk("rst_wn", wn, 1);
    chk("rst_last", last_cmd, 10'h3FF);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_last", last_cmd, 10'h3FF);
      chk("idle_level", level, 0);
      chk("idle_busy", busy, 0);
      chk("idle_cs", cs, 0);
    end
    chk("idle_addr", addr, 0);
    chk("idle_err", err, 0);

    // Alternating round-robin with a full FIFO on the zero-hold instance
    h_req0 = 1'b1; h_req1 = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("rr_ack0", h_ack0, e_ack0[k]);
      chk("rr_ack1", h_ack1, e_ack1[k]);
      chk("rr_level", h_level, e_lvl[k]);
      chk("rr_write", (h_cs && !h_wn) ? h_wd : 32'h0, e_wr[k]);
    end
    h_req0 = 1'b0; h_req1 = 1'b0;

    // Single command, exact write/verify timing and hold gap
    data0 = 10'h155; req0 = 1'b1;
    @(negedge clk);
    chk("s_ack0", ack0, 1);
    data0 = 10'h0AA;
    @(negedge clk);
    chk("s_ack0_once", ack0, 0);
    chk("s_wr_cs", cs, 1);
    chk("s_wr_wn", wn, 0);
    chk("s_wr_data", wd, 32'h155);
    chk("s_wr_level", level, 0);
    @(negedge clk);
    chk("s_ack0_next", ack0, 1);
    chk("s_vf_cs", cs, 1);
    chk("s_vf_wn", wn, 1);
    req0 = 1'b0;
    @(negedge clk);
    chk("s_hold_cs", cs, 0);
    chk("s_last", last_cmd, 10'h155);
    chk("s_err", err, 0);
    chk("s_busy", busy, 1);
    wait_write(n);
    chk("hold_gap", n, 18);
    chk("s_wr2_data", wd, 32'h0AA);
    wait_idle(60);
    chk("s_last2", last_cmd, 10'h0AA);

    // Readback mismatch, sticky flag, clear, clear vs set
    corrupt = 1'b1;
    send(0, 10'h155);
    wait_idle(100);
    chk("mm_set", err, 1);
    chk("mm_last", last_cmd, 10'h155);
    repeat (5) @(negedge clk);
    chk("mm_sticky", err, 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    chk("mm_cleared", err, 0);
    send(0, 10'h155);
    for (int i = 0; i < 60; i++) begin
      if (cs && wn) break;
      @(negedge clk);
    end
    chk("mm_verify_seen", cs && wn, 1);
    err_clear = 1'b1;
    @(negedge clk);
    chk("mm_set_wins", err, 1);
    err_clear = 1'b0;
    corrupt = 1'b0;
    wait_idle(100);

    // Full FIFO with same-cycle push/pop, ordering across pointer wrap
    wlog.delete();
    send(0, 10'h100);
    send(1, 10'h201);
    send(1, 10'h202);
    send(1, 10'h203);
    send(1, 10'h204);
    chk("full_level", level, 4);
    data1 = 10'h205; req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_stall", ack1, 0);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack1) break;
    end
    chk("full_ack", ack1, 1);
    chk("full_pushpop_level", level, 4);
    chk("full_wr_data", (cs && !wn) ? wd : 32'h0, 32'h201);
    req1 = 1'b0;
    wait_idle(300);
    chk("order_count", wlog.size(), 6);
    for (int i = 0; i < 6; i++)
      chk("order", (i < wlog.size()) ? {22'b0, wlog[i]} : 32'hFFFF_FFFF, e_order[i]);

    // Reset in the middle of a write
    send(0, 10'h2AA);
    data1 = 10'h2AB; req1 = 1'b1;
    @(negedge clk);
    chk("r_wr_active", cs && !wn, 1);
    chk("r_wr_data", wd, 32'h2AA);
    chk("r_level", level, 1);
    req1 = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("r_cs", cs, 0);
    chk("r_wn", wn, 1);
    chk("r_level0", level, 0);
    chk("r_last", last_cmd, 10'h3FF);
    chk("r_err", err, 0);
    chk("r_ack1", ack1, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(0, 10'h0F0);
    wait_write(n);
    chk("r_new_wr", (cs && !wn) ? wd : 32'h0, 32'h0F0);
    wait_idle(60);
    chk("r_new_last", last_cmd, 10'h0F0);
    chk("r_new_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/zoom_pio_cmd_sequencer.md
Name: zoom_pio_cmd_sequencer

Overview:
Arbitrates 10-bit zoom/control commands from two requesters (HPS bridge path, local control path) and buffers them in a small FIFO. Drives them one at a time into the 10-bit output PIO through its Avalon-MM slave port (address 0), then reads the register back to check the write landed. Enforces a minimum hold time between successive PIO updates so downstream coprocessor logic sees each command settle. Sits between the command sources and the PIO slave inside the SoC fabric.

Parameters:
DATA_W, 10, command width; equals PIO width.
FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2.
HOLD_CYCLES, 16, idle cycles enforced after each PIO update.
CNT_W, 8, hold counter width; must satisfy HOLD_CYCLES < 2**CNT_W.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 command valid; held until ack0
data0  in  DATA_W  requester 0 command; stable while req0=1
ack0  out  1  one-cycle accept pulse to requester 0
req1  in  1  requester 1 command valid
data1  in  DATA_W  requester 1 command
ack1  out  1  one-cycle accept pulse to requester 1
pio_address  out  2  Avalon address to PIO; always 0
pio_chipselect  out  1  Avalon chipselect
pio_write_n  out  1  Avalon write, active-low
pio_writedata  out  32  Avalon write data, {22'b0, cmd}
pio_readdata  in  32  PIO read data; combinational, zero wait states
busy  out  1  high when state is not IDLE or FIFO is non-empty
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
last_cmd  out  DATA_W  last command verified in the PIO
err_mismatch  out  1  sticky readback-mismatch flag
err_clear  in  1  synchronous clear of err_mismatch

Behaviour:
- Reset, clocked by clk with reset_n asynchronous active-low: ack0/ack1=0, pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0, busy=0, fifo_level=0, last_cmd=all ones (1023, matches PIO reset value), err_mismatch=0, RR pointer=requester 0, state=IDLE.
- Reset mid-operation aborts any in-flight transfer and flushes the FIFO. The Avalon strobes deassert immediately.
- Arbitration:
  - One grant per cycle, only when the FIFO is not full; the grant is registered.
  - Ack pulses in cycle N+1 after a grant decision on req in cycle N. The entry is written to the FIFO in the same edge.
  - A requester with ack high this cycle is masked from arbitration this cycle, so the same request cannot be double-accepted.
  - Round-robin: if both requesters are eligible, grant the one the pointer selects. The pointer then moves to the other requester. With a single eligible requester, grant it and move the pointer to the other requester.
  - When the FIFO is full, no acks; requests stall.
- FIFO:
  - Push and pop in the same cycle are allowed, including when full (pop frees the slot, push accepted) and when empty (no pop occurs).
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - fifo_level changes by +1, -1 or 0 per cycle.
- FSM states: IDLE, WRITE, VERIFY, HOLD.
  - IDLE: FIFO non-empty -> pop the head into the cmd register; go to WRITE. Otherwise stay.
  - WRITE (1 cycle): chipselect=1, write_n=0, address=0, writedata={22'b0,cmd}. Go to VERIFY.
  - VERIFY (1 cycle): chipselect=1, write_n=1.
    - Mismatch if pio_readdata[9:0] != cmd or pio_readdata[31:10] != 0; a mismatch sets err_mismatch.
    - last_cmd <= cmd regardless of the result.
    - Load the counter with HOLD_CYCLES; go to HOLD.
  - HOLD: strobes low. Counter==0 -> IDLE, else decrement. HOLD therefore lasts HOLD_CYCLES+1 cycles.
- Timing: command popped in IDLE at cycle T -> write at T+1, verify at T+2, earliest next pop at T+HOLD_CYCLES+4.
- Strobes are registered outputs. No Avalon strobes in IDLE or HOLD.
- err_clear and a mismatch in the same cycle: set wins.

Decomposition:
- Shared package zoom_pio_pkg holds:
  - state enum (IDLE/WRITE/VERIFY/HOLD)
  - PIO_DATA_W=10
  - PIO_RESET_VAL=10'h3FF
  - PIO_DATA_ADDR=2'd0
- Natural sub-module: zoom_cmd_fifo, a synchronous FIFO parameterised by width/depth with push/pop/full/empty/level. Arbiter and FSM stay in the top module.

Test Plan:
1. Reset release, no requests -> last_cmd=0x3FF, fifo_level=0, busy=0, pio_chipselect=0 for 50 cycles.
2. req0 with data0=0x155 -> ack0 pulses once. Then: write cycle with pio_writedata=0x00000155, verify cycle, last_cmd=0x155, err_mismatch=0. Next write no earlier than HOLD_CYCLES+4 cycles after the pop.
3. req0 and req1 held continuously, data0=0x001, data1=0x002, HOLD_CYCLES=0 -> acks alternate 0,1,0,1. PIO writes alternate 0x001/0x002. The FIFO fills to 4 and acks stall until a pop.
4. Slave model returns readdata=0x00000154 for a written 0x155 -> err_mismatch=1 and stays set. err_clear pulse -> 0. err_clear coincident with a new mismatch -> stays 1.
5. Fill the FIFO to FIFO_DEPTH with req1 held while IDLE pops -> same-cycle push and pop when full; fifo_level stays 4; no command lost or duplicated (scoreboard order check across pointer wrap).
6. Assert reset_n low during WRITE of 0x2AA -> strobes drop immediately, fifo_level=0, last_cmd=0x3FF. After release, new req0=0x0F0 is processed normally.
